// File: rtl/dbg_cmd_sequencer.sv
// Debug command sequencer: assembles UART bytes into one DEBUG_FN command,
// issues it to the debug controller, waits for completion and returns read
// data plus an ack (or error) byte to the UART transmitter.
module dbg_cmd_sequencer #(
  parameter int          TIMEOUT_CYCLES = 1_000_000,
  parameter logic [7:0]  ERR_BYTE       = 8'hEE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic        ctrlr_busy,
  input  logic [31:0] d_rd,
  output logic [3:0]  debug_fn,
  output logic [31:0] addr,
  output logic [31:0] d_in,
  output logic        out_valid
);

  // Idle counter is wide enough to hold TIMEOUT_CYCLES-1 (and never 0 bits wide).
  localparam int             CW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]  IDLE_LAST = CW'(TIMEOUT_CYCLES - 1);

  localparam logic [3:0] FN_STATUS    = 4'd5;
  localparam logic [3:0] FN_BR_PT_ADD = 4'd6;
  localparam logic [3:0] FN_MEM_RD    = 4'd8;
  localparam logic [3:0] FN_MEM_WR    = 4'd9;
  localparam logic [3:0] FN_REG_RD    = 4'd10;
  localparam logic [3:0] FN_REG_WR    = 4'd11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RX_ADDR,
    S_RX_DATA,
    S_ISSUE,
    S_WAIT_DONE,
    S_TX_DATA,
    S_TX_ACK,
    S_TX_ERR
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    fn_q, fn_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   din_q, din_d;
  logic [31:0]   rd_buf_q, rd_buf_d;
  logic [1:0]    byte_cnt_q, byte_cnt_d;
  logic [CW-1:0] idle_cnt_q, idle_cnt_d;
  logic          wait_first_q, wait_first_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_valid_q, tx_valid_d;

  logic          opcode_ok;
  logic          tx_done;

  // Commands carrying a 4-byte data word after the address.
  function automatic logic has_wdata(input logic [3:0] fn);
    return (fn == FN_MEM_WR) || (fn == FN_REG_WR);
  endfunction

  // Commands that return a 32-bit read word before the ack byte.
  function automatic logic has_rdata(input logic [3:0] fn);
    return (fn == FN_STATUS) || (fn == FN_MEM_RD) || (fn == FN_REG_RD);
  endfunction

  assign opcode_ok = (rx_data[7:4] == 4'd0) && (rx_data[3:0] != 4'd0) &&
                     (rx_data[3:0] <= FN_REG_WR);
  assign tx_done   = tx_valid_q && tx_ready;

  // Next-state and datapath logic for the whole command sequence.
  always_comb begin
    state_d      = state_q;
    fn_d         = fn_q;
    addr_d       = addr_q;
    din_d        = din_q;
    rd_buf_d     = rd_buf_q;
    byte_cnt_d   = byte_cnt_q;
    idle_cnt_d   = idle_cnt_q;
    wait_first_d = wait_first_q;
    tx_data_d    = tx_data_q;
    tx_valid_d   = tx_valid_q;

    case (state_q)
      S_IDLE: begin
        byte_cnt_d = 2'd0;
        idle_cnt_d = '0;
        if (rx_valid) begin
          if (opcode_ok) begin
            fn_d = rx_data[3:0];
            if (rx_data[3:0] >= FN_BR_PT_ADD) begin
              state_d = S_RX_ADDR;
            end else begin
              state_d = S_ISSUE;
            end
          end else begin
            state_d    = S_TX_ERR;
            tx_valid_d = 1'b1;
            tx_data_d  = ERR_BYTE;
          end
        end
      end

      S_RX_ADDR: begin
        // A byte in the expiry cycle still wins over the timeout.
        if (rx_valid) begin
          addr_d     = {addr_q[23:0], rx_data};
          idle_cnt_d = '0;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            state_d = has_wdata(fn_q) ? S_RX_DATA : S_ISSUE;
          end
        end else if (idle_cnt_q == IDLE_LAST) begin
          state_d    = S_TX_ERR;
          tx_valid_d = 1'b1;
          tx_data_d  = ERR_BYTE;
        end else begin
          idle_cnt_d = idle_cnt_q + CW'(1);
        end
      end

      S_RX_DATA: begin
        if (rx_valid) begin
          din_d      = {din_q[23:0], rx_data};
          idle_cnt_d = '0;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            state_d = S_ISSUE;
          end
        end else if (idle_cnt_q == IDLE_LAST) begin
          state_d    = S_TX_ERR;
          tx_valid_d = 1'b1;
          tx_data_d  = ERR_BYTE;
        end else begin
          idle_cnt_d = idle_cnt_q + CW'(1);
        end
      end

      S_ISSUE: begin
        if (!ctrlr_busy) begin
          state_d      = S_WAIT_DONE;
          wait_first_d = 1'b1;
        end
      end

      S_WAIT_DONE: begin
        // First cycle skipped: the controller has not raised busy yet.
        wait_first_d = 1'b0;
        if (!wait_first_q && !ctrlr_busy) begin
          rd_buf_d   = d_rd;
          tx_valid_d = 1'b1;
          byte_cnt_d = 2'd0;
          if (has_rdata(fn_q)) begin
            state_d   = S_TX_DATA;
            tx_data_d = d_rd[31:24];
          end else begin
            state_d   = S_TX_ACK;
            tx_data_d = {4'hA, fn_q};
          end
        end
      end

      S_TX_DATA: begin
        // rd_buf shifts left so its second byte is always the next to send.
        if (tx_done) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            state_d   = S_TX_ACK;
            tx_data_d = {4'hA, fn_q};
          end else begin
            tx_data_d = rd_buf_q[23:16];
            rd_buf_d  = {rd_buf_q[23:0], 8'h00};
          end
        end
      end

      S_TX_ACK, S_TX_ERR: begin
        if (tx_done) begin
          tx_valid_d = 1'b0;
          state_d    = S_IDLE;
        end
      end

      default: begin
        state_d    = S_IDLE;
        tx_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      fn_q         <= 4'd0;
      addr_q       <= 32'd0;
      din_q        <= 32'd0;
      rd_buf_q     <= 32'd0;
      byte_cnt_q   <= 2'd0;
      idle_cnt_q   <= '0;
      wait_first_q <= 1'b0;
      tx_data_q    <= 8'd0;
      tx_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      fn_q         <= fn_d;
      addr_q       <= addr_d;
      din_q        <= din_d;
      rd_buf_q     <= rd_buf_d;
      byte_cnt_q   <= byte_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
      wait_first_q <= wait_first_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
    end
  end

  // The strobe must coincide with the first non-busy cycle in ISSUE, so it is
  // decoded from the registered state and the live busy input.
  assign out_valid = (state_q == S_ISSUE) && !ctrlr_busy;
  assign debug_fn  = fn_q;
  assign addr      = addr_q;
  assign d_in      = din_q;
  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;

endmodule

// File: tb/tb_dbg_cmd_sequencer.sv
// Self-checking bench for dbg_cmd_sequencer: directed scenarios with literal
// expectations, then random commands checked against a byte-stream model.
module tb_dbg_cmd_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        ext_busy;
  logic        ctl_busy;
  logic        ctrlr_busy;
  logic [31:0] d_rd;
  logic [3:0]  debug_fn;
  logic [31:0] addr;
  logic [31:0] d_in;
  logic        out_valid;

  assign ctrlr_busy = ext_busy | ctl_busy;

  always #5 clk = ~clk;

  dbg_cmd_sequencer #(
    .TIMEOUT_CYCLES(16),
    .ERR_BYTE(8'hEE)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .ctrlr_busy(ctrlr_busy),
    .d_rd(d_rd),
    .debug_fn(debug_fn),
    .addr(addr),
    .d_in(d_in),
    .out_valid(out_valid)
  );

  typedef struct packed {
    logic [3:0]  fn;
    logic [31:0] a;
    logic [31:0] d;
  } iss_t;

  int          checks = 0;
  int          failures = 0;
  iss_t        exp_iss[$];
  logic [7:0]  exp_tx[$];
  logic [31:0] m_addr;
  logic [31:0] m_din;
  logic [31:0] next_rd;
  int          busy_len_cfg;
  int          ready_mode;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic expect_issue(input logic [3:0] fn, input logic [31:0] a, input logic [31:0] d);
    iss_t e;
    e.fn = fn;
    e.a  = a;
    e.d  = d;
    exp_iss.push_back(e);
  endtask

  // Model rule: one issue per command, then read bytes (MSB first) for
  // STATUS/MEM_RD/REG_RD, then ack {A, fn}.
  task automatic expect_cmd(input logic [3:0] fn);
    expect_issue(fn, m_addr, m_din);
    if (fn == 4'd5 || fn == 4'd8 || fn == 4'd10) begin
      for (int i = 3; i >= 0; i--) exp_tx.push_back(next_rd[8*i +: 8]);
    end
    exp_tx.push_back({4'hA, fn});
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((exp_iss.size() + exp_tx.size()) != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", exp_iss.size() + exp_tx.size(), 0);
    exp_iss.delete();
    exp_tx.delete();
    tick();
    tick();
    chk("quiet_tx_valid", tx_valid, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_debug_fn", debug_fn, 0);
    chk("rst_addr", addr, 0);
    chk("rst_d_in", d_in, 0);
    exp_iss.delete();
    exp_tx.delete();
    m_addr = 32'd0;
    m_din  = 32'd0;
    reset  = 1'b0;
    tick();
  endtask

  function automatic int pick_gap();
    int r;
    r = $urandom_range(0, 9);
    if (r < 6) return 0;
    if (r < 9) return $urandom_range(1, 3);
    return 15;
  endfunction

  task automatic rand_cmd(input int idx);
    logic [7:0] op;
    logic [7:0] bytes [8];
    logic [3:0] fn;
    int nb;
    int tpos;
    int sent;
    if ($urandom_range(0, 7) == 0) op = 8'($urandom_range(0, 255));
    else op = 8'($urandom_range(1, 11));
    ready_mode = $urandom_range(0, 2);
    next_rd    = $urandom;
    if (!(op[7:4] == 4'd0 && op[3:0] >= 4'd1 && op[3:0] <= 4'd11)) begin
      $display("cmd %0d op=%h bad opcode", idx, op);
      exp_tx.push_back(8'hEE);
      send_byte(op, 0);
      drain(200);
      return;
    end
    fn   = op[3:0];
    nb   = (fn >= 4'd6) ? ((fn == 4'd9 || fn == 4'd11) ? 8 : 4) : 0;
    tpos = (nb > 0 && $urandom_range(0, 5) == 0) ? $urandom_range(0, nb - 1) : -1;
    for (int i = 0; i < 8; i++) bytes[i] = 8'($urandom);
    sent = (tpos >= 0) ? tpos : nb;
    for (int i = 0; i < sent; i++) begin
      if (i < 4) m_addr = {m_addr[23:0], bytes[i]};
      else       m_din  = {m_din[23:0], bytes[i]};
    end
    if (tpos >= 0) exp_tx.push_back(8'hEE);
    else expect_cmd(fn);
    $display("cmd %0d op=%h bytes=%0d timeout_at=%0d addr=%h d_in=%h rd=%h", idx, op, nb, tpos, m_addr, m_din, next_rd);
    send_byte(op, (nb > 0) ? pick_gap() : 0);
    for (int i = 0; i < sent; i++) send_byte(bytes[i], (i < nb - 1) ? pick_gap() : 0);
    drain(300);
  endtask

  // Controller model: busy for a few cycles after each strobe, junk on d_rd
  // while busy, the intended read word once it goes idle.
  initial begin
    ctl_busy = 1'b0;
    d_rd     = 32'd0;
    forever begin
      @(negedge clk);
      if (!reset && out_valid) begin
        int n;
        n = (busy_len_cfg > 0) ? busy_len_cfg : $urandom_range(1, 4);
        tick();
        ctl_busy = 1'b1;
        d_rd     = $urandom;
        repeat (n) begin
          tick();
          d_rd = $urandom;
        end
        ctl_busy = 1'b0;
        d_rd     = next_rd;
      end
    end
  end

  // Transmitter ready pattern.
  initial begin
    tx_ready = 1'b1;
    forever begin
      tick();
      case (ready_mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = ~tx_ready;
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Compare process: issues and transmitted bytes against the expectation queues.
  initial begin
    iss_t       e;
    logic [7:0] b;
    logic       prev_hold;
    logic [7:0] prev_data;
    prev_hold = 1'b0;
    prev_data = 8'd0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_hold = 1'b0;
      end else begin
        if (out_valid) begin
          if (exp_iss.size() == 0) begin
            chk("spurious_out_valid", out_valid, 0);
          end else begin
            e = exp_iss.pop_front();
            chk("issue_fn", debug_fn, e.fn);
            chk("issue_addr", addr, e.a);
            chk("issue_d_in", d_in, e.d);
          end
        end
        if (prev_hold) begin
          chk("tx_hold_valid", tx_valid, 1);
          chk("tx_hold_data", tx_data, prev_data);
        end
        if (tx_valid && tx_ready) begin
          if (exp_tx.size() == 0) begin
            chk("spurious_tx", tx_valid, 0);
          end else begin
            b = exp_tx.pop_front();
            chk("tx_byte", tx_data, b);
          end
        end
        prev_hold = tx_valid && !tx_ready;
        prev_data = tx_data;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] seq[$];
    int n;
    reset        = 1'b1;
    rx_data      = 8'd0;
    rx_valid     = 1'b0;
    ext_busy     = 1'b0;
    ready_mode   = 0;
    busy_len_cfg = 0;
    next_rd      = 32'd0;
    m_addr       = 32'd0;
    m_din        = 32'd0;
    tick();
    do_reset();

    // 1: PAUSE, controller busy for 3 cycles after the strobe.
    $display("test1 PAUSE");
    busy_len_cfg = 3;
    expect_issue(4'd1, 32'h0, 32'h0);
    exp_tx.push_back(8'hA1);
    send_byte(8'h01, 0);
    @(negedge clk);
    chk("t1_out_valid_latency", out_valid, 1);
    chk("t1_debug_fn", debug_fn, 1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tx_valid && n < 40);
    chk("t1_tx_latency", n, 5);
    drain(100);
    busy_len_cfg = 0;

    // 2: MEM_WR.
    $display("test2 MEM_WR");
    expect_issue(4'd9, 32'h0000_1000, 32'hDEAD_BEEF);
    exp_tx.push_back(8'hA9);
    seq = '{8'h09, 8'h00, 8'h00, 8'h10, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    foreach (seq[i]) send_byte(seq[i], 0);
    drain(100);

    // 3: MEM_RD with tx_ready toggling.
    $display("test3 MEM_RD");
    ready_mode = 1;
    next_rd    = 32'h1234_5678;
    expect_issue(4'd8, 32'h0000_0040, 32'hDEAD_BEEF);
    seq = '{8'h12, 8'h34, 8'h56, 8'h78, 8'hA8};
    foreach (seq[i]) exp_tx.push_back(seq[i]);
    seq = '{8'h08, 8'h00, 8'h00, 8'h00, 8'h40};
    foreach (seq[i]) send_byte(seq[i], 0);
    drain(100);
    ready_mode = 0;

    // 4: bad opcode, inter-byte timeout, recovery, gap at the limit.
    $display("test4 bad opcode");
    exp_tx.push_back(8'hEE);
    send_byte(8'h3F, 0);
    drain(100);
    $display("test4 timeout");
    exp_tx.push_back(8'hEE);
    send_byte(8'h06, 0);
    send_byte(8'h00, 0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tx_valid && n < 60);
    chk("t4_timeout_cycles", n, 17);
    drain(100);
    $display("test4 recovery PAUSE");
    expect_issue(4'd1, 32'h0000_4000, 32'hDEAD_BEEF);
    exp_tx.push_back(8'hA1);
    send_byte(8'h01, 0);
    drain(100);
    $display("test4 gap of 15 idle cycles accepted");
    expect_issue(4'd6, 32'h0000_0007, 32'hDEAD_BEEF);
    exp_tx.push_back(8'hA6);
    seq = '{8'h06, 8'h00, 8'h00, 8'h00, 8'h07};
    foreach (seq[i]) send_byte(seq[i], (i < 4) ? 15 : 0);
    drain(100);

    // 5: issue held off by a busy controller.
    $display("test5 RESUME with busy controller");
    expect_issue(4'd2, 32'h0000_0007, 32'hDEAD_BEEF);
    exp_tx.push_back(8'hA2);
    ext_busy = 1'b1;
    send_byte(8'h02, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t5_held_off", out_valid, 0);
      tick();
    end
    ext_busy = 1'b0;
    @(negedge clk);
    chk("t5_out_valid_first_idle", out_valid, 1);
    tick();
    @(negedge clk);
    chk("t5_out_valid_width", out_valid, 0);
    drain(100);

    // 6: reset during the second address byte, then STATUS.
    $display("test6 reset mid-command");
    send_byte(8'h06, 0);
    send_byte(8'h00, 0);
    rx_data  = 8'h00;
    rx_valid = 1'b1;
    reset    = 1'b1;
    tick();
    rx_valid = 1'b0;
    tick();
    chk("t6_rst_out_valid", out_valid, 0);
    chk("t6_rst_tx_valid", tx_valid, 0);
    chk("t6_rst_addr", addr, 0);
    reset = 1'b0;
    tick();
    next_rd = 32'h0000_000F;
    expect_issue(4'd5, 32'h0, 32'h0);
    seq = '{8'h00, 8'h00, 8'h00, 8'h0F, 8'hA5};
    foreach (seq[i]) exp_tx.push_back(seq[i]);
    send_byte(8'h05, 0);
    drain(100);

    // Random commands against the model.
    do_reset();
    for (int i = 0; i < 60; i++) rand_cmd(i);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
